// File: rtl/fle_fabric_cfg_param.sv
// Fracturable logic element: K-LUT (splittable into two (K-1)-LUTs), two scan FFs, output/D muxes, serial config chain.
// Latency: LUT path combinational; FF path 1 cycle; fabric_reg_in -> ff1 output 2 cycles.
// No backpressure: user FFs freeze while ccff_en shifts config; outputs optionally gated until cfg_done.
module fle_fabric_cfg_param #(
  parameter int K        = 4,
  parameter int OUT_GATE = 1
) (
  input  logic         prog_clk,
  input  logic         prog_reset,
  input  logic         Test_en,
  input  logic [K-1:0] fabric_in,
  input  logic         fabric_reg_in,
  input  logic         fabric_sc_in,
  input  logic         fabric_srst,
  input  logic         ccff_en,
  input  logic         ccff_head,
  output logic [1:0]   fabric_out,
  output logic         fabric_reg_out,
  output logic         fabric_sc_out,
  output logic         ccff_tail,
  output logic         cfg_done
);

  localparam int LUT_BITS = 1 << K;
  localparam int CFG_BITS = LUT_BITS + 7;
  localparam int CW       = $clog2(CFG_BITS + 1);

  // Config field positions above the truth table
  localparam int FRAC_IDX  = LUT_BITS;
  localparam int OSEL0_IDX = LUT_BITS + 1;
  localparam int OSEL1_IDX = LUT_BITS + 2;
  localparam int DSEL0_IDX = LUT_BITS + 3;
  localparam int DSEL1_IDX = LUT_BITS + 4;
  localparam int INIT0_IDX = LUT_BITS + 5;
  localparam int INIT1_IDX = LUT_BITS + 6;

  logic [CFG_BITS-1:0] cfg;
  logic [CW-1:0]       cnt;
  logic                ff0;
  logic                ff1;

  logic [LUT_BITS-1:0] truth;
  logic [K-1:0]        lo_addr;
  logic [K-1:0]        hi_addr;
  logic                lut_lo;
  logic                lut_hi;
  logic                lut_full;
  logic                lut0;
  logic                lut1;
  logic                out0_raw;
  logic                out1_raw;
  logic                gate;

  // Config shift register with bit counter; a shift after done restarts the count at 1
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cfg      <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
    end else if (ccff_en) begin
      cfg <= {cfg[CFG_BITS-2:0], ccff_head};
      if (cfg_done) begin
        cnt      <= CW'(1);
        cfg_done <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(CFG_BITS - 1)) begin
          cfg_done <= 1'b1;
        end
      end
    end
  end

  // Fracturable LUT: lo/hi halves share the low K-1 address bits
  always_comb begin
    truth    = cfg[LUT_BITS-1:0];
    lo_addr  = {1'b0, fabric_in[K-2:0]};
    hi_addr  = {1'b1, fabric_in[K-2:0]};
    lut_lo   = truth[lo_addr];
    lut_hi   = truth[hi_addr];
    lut_full = truth[fabric_in];
    lut0     = cfg[FRAC_IDX] ? lut_lo : lut_full;
    lut1     = lut_hi;
  end

  // User FFs: reset > freeze during shift > sync init > scan shift > functional D
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      ff0 <= 1'b0;
      ff1 <= 1'b0;
    end else if (ccff_en) begin
      ff0 <= ff0;
      ff1 <= ff1;
    end else if (fabric_srst) begin
      ff0 <= cfg[INIT0_IDX];
      ff1 <= cfg[INIT1_IDX];
    end else if (Test_en) begin
      ff0 <= fabric_sc_in;
      ff1 <= ff0;
    end else begin
      ff0 <= cfg[DSEL0_IDX] ? fabric_reg_in : lut0;
      ff1 <= cfg[DSEL1_IDX] ? ff0 : lut1;
    end
  end

  // Output select and optional gating until the element is fully configured
  always_comb begin
    gate           = (OUT_GATE != 0) ? cfg_done : 1'b1;
    out0_raw       = cfg[OSEL0_IDX] ? ff0 : lut0;
    out1_raw       = cfg[OSEL1_IDX] ? ff1 : lut1;
    fabric_out     = {out1_raw & gate, out0_raw & gate};
    fabric_reg_out = ff1 & gate;
    fabric_sc_out  = ff1 & gate;
  end

  assign ccff_tail = cfg[CFG_BITS-1];

endmodule

// File: tb/tb_fle_fabric_cfg_param.sv
// Bench for fle_fabric_cfg_param (K=4, OUT_GATE=1): directed scenarios plus random traffic.
// Expected outputs come from a bit-queue reference model and are checked each cycle by a monitor.
// Stimulus pushes expectations; the monitor pops and compares at the falling edge.
module tb_fle_fabric_cfg_param;

  logic       prog_clk = 1'b0;
  logic       prog_reset;
  logic       Test_en;
  logic [3:0] fabric_in;
  logic       fabric_reg_in;
  logic       fabric_sc_in;
  logic       fabric_srst;
  logic       ccff_en;
  logic       ccff_head;
  logic [1:0] fabric_out;
  logic       fabric_reg_out;
  logic       fabric_sc_out;
  logic       ccff_tail;
  logic       cfg_done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] out;
    logic       reg_out;
    logic       sc_out;
    logic       tail;
    logic       done;
  } exp_t;

  exp_t sbq[$];
  int   tick_no = 0;

  // Reference model state: configuration as a list of bits (index = cfg position)
  bit m_cfg[$];
  int m_shifts;
  bit m_done;
  bit m_f0, m_f1;

  fle_fabric_cfg_param #(.K(4), .OUT_GATE(1)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .Test_en       (Test_en),
    .fabric_in     (fabric_in),
    .fabric_reg_in (fabric_reg_in),
    .fabric_sc_in  (fabric_sc_in),
    .fabric_srst   (fabric_srst),
    .ccff_en       (ccff_en),
    .ccff_head     (ccff_head),
    .fabric_out    (fabric_out),
    .fabric_reg_out(fabric_reg_out),
    .fabric_sc_out (fabric_sc_out),
    .ccff_tail     (ccff_tail),
    .cfg_done      (cfg_done)
  );

  always #5 prog_clk = ~prog_clk;

  function automatic void model_reset();
    m_cfg = {};
    for (int i = 0; i < 23; i++) m_cfg.push_back(1'b0);
    m_shifts = 0;
    m_done   = 1'b0;
    m_f0     = 1'b0;
    m_f1     = 1'b0;
  endfunction

  function automatic bit model_lut0(input int a);
    bit full, lo;
    full = m_cfg[a];
    lo   = m_cfg[a % 8];
    return m_cfg[16] ? lo : full;
  endfunction

  function automatic bit model_lut1(input int a);
    return m_cfg[8 + (a % 8)];
  endfunction

  function automatic exp_t model_out(input int a);
    exp_t e;
    bit o0, o1;
    o0 = m_cfg[17] ? m_f0 : model_lut0(a);
    o1 = m_cfg[18] ? m_f1 : model_lut1(a);
    e.out     = {o1 & m_done, o0 & m_done};
    e.reg_out = m_f1 & m_done;
    e.sc_out  = m_f1 & m_done;
    e.tail    = m_cfg[22];
    e.done    = m_done;
    return e;
  endfunction

  function automatic void model_step();
    int a;
    bit l0, l1, old0;
    a    = int'(fabric_in);
    l0   = model_lut0(a);
    l1   = model_lut1(a);
    old0 = m_f0;
    if (prog_reset) begin
      model_reset();
    end else if (ccff_en) begin
      m_cfg.push_front(ccff_head);
      void'(m_cfg.pop_back());
      if (m_done) begin
        m_shifts = 1;
        m_done   = 1'b0;
      end else begin
        m_shifts++;
        if (m_shifts == 23) m_done = 1'b1;
      end
    end else if (fabric_srst) begin
      m_f0 = m_cfg[21];
      m_f1 = m_cfg[22];
    end else if (Test_en) begin
      m_f0 = fabric_sc_in;
      m_f1 = old0;
    end else begin
      m_f0 = m_cfg[19] ? fabric_reg_in : l0;
      m_f1 = m_cfg[20] ? old0 : l1;
    end
  endfunction

  // One cycle: queue the expectation for current inputs, then clock model and DUT together
  task automatic tick();
    sbq.push_back(model_out(int'(fabric_in)));
    @(posedge prog_clk);
    model_step();
    tick_no++;
    #1;
  endtask

  // Shift a 23-bit word so that w[i] ends up at cfg[i]
  task automatic load(input logic [22:0] w);
    for (int i = 22; i >= 0; i--) begin
      ccff_en   = 1'b1;
      ccff_head = w[i];
      tick();
    end
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  // Monitor: compare every DUT output against the oldest queued expectation
  initial begin
    exp_t e, act;
    forever begin
      @(negedge prog_clk);
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = '{out: fabric_out, reg_out: fabric_reg_out, sc_out: fabric_sc_out,
                tail: ccff_tail, done: cfg_done};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL outputs tick=%0d got out=%b reg=%b sc=%b tail=%b done=%b expected out=%b reg=%b sc=%b tail=%b done=%b",
                   tick_no, act.out, act.reg_out, act.sc_out, act.tail, act.done,
                   e.out, e.reg_out, e.sc_out, e.tail, e.done);
        end
      end
    end
  end

  initial begin
    logic [22:0] w;
    prog_reset    = 1'b1;
    Test_en       = 1'b0;
    fabric_in     = 4'h0;
    fabric_reg_in = 1'b0;
    fabric_sc_in  = 1'b0;
    fabric_srst   = 1'b0;
    ccff_en       = 1'b0;
    ccff_head     = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    model_reset();
    prog_reset = 1'b0;
    tick();  // reset state

    // AND4 LUT, unfractured, LUT outputs
    w = {7'b0, 16'h8000};
    load(w);
    fabric_in = 4'hF; tick();
    fabric_in = 4'hE; tick();

    // Fractured XOR pattern: in[3] ignored
    w = {6'b0, 1'b1, 16'h6996};
    load(w);
    fabric_in = 4'b0001; tick();
    fabric_in = 4'b1001; tick();

    // Register chain through ff0 -> ff1
    w = 23'h0;
    w[17] = 1'b1; w[18] = 1'b1; w[19] = 1'b1; w[20] = 1'b1;
    load(w);
    fabric_reg_in = 1'b1; tick();
    fabric_reg_in = 1'b0; repeat (3) tick();

    // Scan path
    Test_en = 1'b1;
    fabric_sc_in = 1'b1; tick();
    fabric_sc_in = 1'b0; repeat (3) tick();
    Test_en = 1'b0;

    // Init via srst, then freeze during a short reconfig shift
    w = 23'h0;
    w[17] = 1'b1; w[18] = 1'b1; w[21] = 1'b1; w[22] = 1'b1; w[20] = 1'b1;
    load(w);
    fabric_srst = 1'b1; tick();
    fabric_srst = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      ccff_en       = 1'b1;
      ccff_head     = 1'(i);
      fabric_reg_in = ~fabric_reg_in;
      fabric_srst   = 1'(i);
      Test_en       = 1'(i + 1);
      tick();
    end
    ccff_en = 1'b0; fabric_srst = 1'b0; Test_en = 1'b0;
    tick();

    // Reset mid-load, then a fresh full load
    for (int i = 0; i < 10; i++) begin
      ccff_en = 1'b1; ccff_head = 1'b1; tick();
    end
    prog_reset = 1'b1; tick();
    prog_reset = 1'b0; ccff_en = 1'b0; tick();
    w = {7'b0, 16'hFFFF};
    load(w);
    fabric_in = 4'h3; tick();

    // Random traffic
    for (int r = 0; r < 25; r++) begin
      w = 23'($urandom);
      load(w);
      for (int c = 0; c < 30; c++) begin
        ccff_en       = ($urandom_range(0, 19) == 0);
        ccff_head     = 1'($urandom);
        fabric_srst   = ($urandom_range(0, 14) == 0);
        Test_en       = ($urandom_range(0, 3) == 0);
        fabric_in     = 4'($urandom);
        fabric_reg_in = 1'($urandom);
        fabric_sc_in  = 1'($urandom);
        prog_reset    = ($urandom_range(0, 99) == 0);
        tick();
      end
      ccff_en = 1'b0; fabric_srst = 1'b0; Test_en = 1'b0; prog_reset = 1'b0;
    end

    repeat (2) @(negedge prog_clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
